// File: rtl/lhs_seq.sv
// lhs_seq: multi-bit shift/rotate sequencer for the single-bit lhs unit.
//
// Takes a shift request (operand, dir, mode, count). It issues one lhs step
// per bit and feeds the unit's registered output and carry back into the
// work register. The final value and carry are presented with a one-cycle
// done strobe.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   start               request strobe, sampled only in IDLE
//   dir, mode, count    0=left/1=right; 00 lsl, 01 rcl, 10 rot, 11 asr; steps
//   operand, carry_flag value to shift, incoming carry
//   lhs_operation       01 left, 10 right, 00 when not stepping
//   lhs_in              working value presented to lhs
//   lhs_carry_in        fill bit for the current step
//   lhs_step            clock qualifier for the lhs unit
//   lhs_out             registered result of the lhs unit
//   lhs_carry_out       registered carry of the lhs unit
//   result, carry       final value/carry, held until the next accepted start
//   busy, done          not-idle flag, one-cycle completion strobe
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// ISSUE   | lhs_step high, lhs registers W on this edge
// CAPTURE | lhs output valid, fold it back into W/C, count down R
// DONE    | result/carry valid, done strobe
module lhs_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_flag,
  output logic [1:0]       lhs_operation,
  output logic [WIDTH-1:0] lhs_in,
  output logic             lhs_carry_in,
  output logic             lhs_step,
  input  logic [WIDTH-1:0] lhs_out,
  input  logic             lhs_carry_out,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] w;
  logic             c;
  logic [CW-1:0]    r;
  logic             dir_q;
  logic [1:0]       mode_q;

  // result/carry are loaded on the transition into DONE (not from W in DONE)
  // so they are already valid in the cycle done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      w      <= '0;
      c      <= 1'b0;
      r      <= '0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            w      <= operand;
            c      <= carry_flag;
            r      <= count;
            dir_q  <= dir;
            mode_q <= mode;
            if (count == '0) begin
              result <= operand;
              carry  <= carry_flag;
              state  <= S_DONE;
            end else begin
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          w <= lhs_out;
          c <= lhs_carry_out;
          r <= r - 1'b1;
          if (r == CW'(1)) begin
            result <= lhs_out;
            carry  <= lhs_carry_out;
            state  <= S_DONE;
          end else begin
            state  <= S_ISSUE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Fill bit for the next step, chosen from the latched mode and direction.
  always_comb begin
    lhs_carry_in = 1'b0;
    case (mode_q)
      2'b01:   lhs_carry_in = c;
      2'b10:   lhs_carry_in = dir_q ? w[0] : w[WIDTH-1];
      2'b11:   lhs_carry_in = dir_q ? w[WIDTH-1] : 1'b0;
      default: lhs_carry_in = 1'b0;
    endcase
  end

  assign lhs_step      = (state == S_ISSUE);
  assign lhs_operation = lhs_step ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
  assign lhs_in        = w;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_lhs_seq.sv
// Testbench for lhs_seq: behavioural lhs unit, closed-form shift reference.
module tb_lhs_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] count = 4'd0;
  logic [7:0] operand = 8'h00;
  logic       carry_flag = 1'b0;
  logic [1:0] lhs_operation;
  logic [7:0] lhs_in;
  logic       lhs_carry_in;
  logic       lhs_step;
  logic [7:0] lhs_out = 8'h00;
  logic       lhs_carry_out = 1'b0;
  logic [7:0] result;
  logic       carry;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lhs_seq #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .mode(mode),
    .count(count), .operand(operand), .carry_flag(carry_flag),
    .lhs_operation(lhs_operation), .lhs_in(lhs_in),
    .lhs_carry_in(lhs_carry_in), .lhs_step(lhs_step),
    .lhs_out(lhs_out), .lhs_carry_out(lhs_carry_out),
    .result(result), .carry(carry), .busy(busy), .done(done)
  );

  // Attached single-bit lhs unit: registers only on qualified clk edges.
  always @(posedge clk) begin
    if (lhs_step) begin
      if (lhs_operation == 2'b01) begin
        lhs_out       <= {lhs_in[6:0], lhs_carry_in};
        lhs_carry_out <= lhs_in[7];
      end else if (lhs_operation == 2'b10) begin
        lhs_out       <= {lhs_carry_in, lhs_in[7:1]};
        lhs_carry_out <= lhs_in[0];
      end
    end
  end

  // Closed-form reference: returns {carry, result} for an n-step operation.
  function automatic logic [8:0] ref_shift(input logic [7:0] op, input logic cf,
                                           input logic d, input logic [1:0] m,
                                           input logic [3:0] n);
    int k;
    logic [17:0] x18;
    logic [8:0]  x9;
    logic [15:0] x16;
    logic [7:0]  res;
    logic [31:0] v;
    logic signed [8:0]  s9;
    logic signed [31:0] sv;
    k = int'(n);
    if (k == 0) return {cf, op};
    case (m)
      2'b01: begin
        x9 = {cf, op};
        x18 = {x9, x9};
        if (!d) begin x18 = x18 << (k % 9); x9 = x18[17:9]; end
        else    begin x18 = x18 >> (k % 9); x9 = x18[8:0]; end
        return x9;
      end
      2'b10: begin
        x16 = {op, op};
        if (!d) begin x16 = x16 << (k % 8); res = x16[15:8]; return {res[0], res}; end
        else    begin x16 = x16 >> (k % 8); res = x16[7:0];  return {res[7], res}; end
      end
      default: begin
        if (!d) begin
          v = {24'd0, op} << k;
          return {v[8], v[7:0]};
        end else if (m == 2'b00) begin
          v = ({24'd0, op} << 1) >> k;
          return {v[0], v[8:1]};
        end else begin
          s9 = {op, 1'b0};
          sv = s9;
          sv = sv >>> k;
          return {sv[0], sv[8:1]};
        end
      end
    endcase
  endfunction

  // Drives one request and observes it; cycle numbers count from the start
  // cycle. If inj_cyc > 0 a conflicting start is raised in that cycle.
  task automatic run_op(input logic [7:0] op, input logic cf, input logic d,
                        input logic [1:0] m, input logic [3:0] n, input int inj_cyc,
                        output int done_cyc, output int steps, output int bad_steps,
                        output int busy_gaps, output int early_res,
                        output logic [7:0] res, output logic res_c);
    logic [7:0] old_r;
    logic       old_c;
    @(negedge clk);
    old_r = result;
    old_c = carry;
    operand = op; carry_flag = cf; dir = d; mode = m; count = n; start = 1'b1;
    done_cyc = -1; steps = 0; bad_steps = 0; busy_gaps = 0; early_res = 0;
    res = result; res_c = carry;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (inj_cyc > 0 && cyc == inj_cyc) begin
        start = 1'b1; operand = ~op; carry_flag = ~cf; dir = ~d; mode = ~m; count = 4'hF;
      end else if (inj_cyc > 0 && cyc == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (!busy) busy_gaps++;
      if (lhs_step) begin
        steps++;
        if ((cyc % 2) == 0 || lhs_operation !== (d ? 2'b10 : 2'b01)) bad_steps++;
      end else if (lhs_operation !== 2'b00) begin
        bad_steps++;
      end
      if (done) begin
        done_cyc = cyc; res = result; res_c = carry;
      end else if (result !== old_r || carry !== old_c) begin
        early_res++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, lhs_step, lhs_operation, lhs_in, lhs_carry_in, result, carry} !== 23'd0) begin
      bad++;
      $display("FAIL reset_values got busy=%b done=%b step=%b op=%b in=%h cin=%b res=%h c=%b required all 0",
               busy, done, lhs_step, lhs_operation, lhs_in, lhs_carry_in, result, carry);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  typedef struct {
    logic [7:0] op; logic cf; logic d; logic [1:0] m; logic [3:0] n;
    logic [7:0] er; logic ec;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[7];
    int dc, st, bs, bg, er;
    logic [7:0] r;
    logic rc;
    vecs[0] = '{8'h81, 1'b0, 1'b0, 2'b00, 4'd1,  8'h02, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 2'b10, 4'd3,  8'h20, 1'b0};
    vecs[2] = '{8'h90, 1'b0, 1'b1, 2'b11, 4'd2,  8'hE4, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 2'b01, 4'd9,  8'h00, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 2'b00, 4'd0,  8'h5A, 1'b1};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 2'b10, 4'd8,  8'hA5, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 2'b00, 4'd15, 8'h00, 1'b0};
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].cf, vecs[i].d, vecs[i].m, vecs[i].n, 0, dc, st, bs, bg, er, r, rc);
      total++;
      if (dc !== 2 * int'(vecs[i].n) + 1) begin
        bad++; $display("FAIL dir_done_cycle vec=%0d got %0d required %0d", i, dc, 2 * int'(vecs[i].n) + 1);
      end
      total++;
      if (st !== int'(vecs[i].n) || bs !== 0) begin
        bad++; $display("FAIL dir_steps vec=%0d got steps=%0d misplaced=%0d required %0d 0", i, st, bs, vecs[i].n);
      end
      total++;
      if (bg !== 0 || er !== 0) begin
        bad++; $display("FAIL dir_busy_hold vec=%0d got gaps=%0d early=%0d required 0 0", i, bg, er);
      end
      total++;
      if (r !== vecs[i].er || rc !== vecs[i].ec) begin
        bad++; $display("FAIL dir_result vec=%0d got %h/%b required %h/%b", i, r, rc, vecs[i].er, vecs[i].ec);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== vecs[i].er) begin
        bad++; $display("FAIL dir_after_done vec=%0d got done=%b busy=%b res=%h required 0 0 %h", i, done, busy, result, vecs[i].er);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc, st, bs, bg, er;
    logic [7:0] r, op;
    logic rc, cf, d;
    logic [1:0] m;
    logic [3:0] n;
    logic [8:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom); cf = 1'($urandom); d = 1'($urandom);
      m = 2'($urandom); n = 4'($urandom_range(0, 15));
      exp = ref_shift(op, cf, d, m, n);
      run_op(op, cf, d, m, n, 0, dc, st, bs, bg, er, r, rc);
      total++;
      if (dc !== 2 * int'(n) + 1 || st !== int'(n) || bs !== 0 || bg !== 0 || er !== 0) begin
        bad++;
        $display("FAIL rnd_timing i=%0d n=%0d got done=%0d steps=%0d misplaced=%0d gaps=%0d early=%0d",
                 i, n, dc, st, bs, bg, er);
      end
      total++;
      if ({rc, r} !== exp) begin
        bad++;
        $display("FAIL rnd_result i=%0d op=%h cf=%b d=%b m=%b n=%0d got %h/%b required %h/%b",
                 i, op, cf, d, m, n, r, rc, exp[7:0], exp[8]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dc, st, bs, bg, er, extra;
    logic [7:0] r;
    logic rc;
    run_op(8'h3C, 1'b0, 1'b0, 2'b10, 4'd4, 3, dc, st, bs, bg, er, r, rc);
    total++;
    if (dc !== 9 || st !== 4 || bs !== 0) begin
        bad++; $display("FAIL ign_timing got done=%0d steps=%0d misplaced=%0d required 9 4 0", dc, st, bs);
    end
    total++;
    if (r !== 8'hC3 || rc !== 1'b1) begin
      bad++; $display("FAIL ign_result got %h/%b required c3/1", r, rc);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || lhs_step) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL ign_no_queue got %0d active cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int dones, dc, st, bs, bg, er;
    logic [7:0] r;
    logic rc;
    logic [8:0] exp;
    @(negedge clk);
    operand = 8'h77; carry_flag = 1'b1; dir = 1'b0; mode = 2'b01; count = 4'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, lhs_step, lhs_operation, lhs_in, lhs_carry_in, result, carry} !== 23'd0) begin
      bad++;
      $display("FAIL mid_reset_values got busy=%b done=%b step=%b op=%b in=%h cin=%b res=%h c=%b required all 0",
               busy, done, lhs_step, lhs_operation, lhs_in, lhs_carry_in, result, carry);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL mid_reset_no_done got %0d active cycles required 0", dones);
    end
    exp = ref_shift(8'h6B, 1'b0, 1'b1, 2'b11, 4'd3);
    run_op(8'h6B, 1'b0, 1'b1, 2'b11, 4'd3, 0, dc, st, bs, bg, er, r, rc);
    total++;
    if (dc !== 7 || {rc, r} !== exp) begin
      bad++; $display("FAIL mid_reset_recover got done=%0d %h/%b required 7 %h/%b", dc, r, rc, exp[7:0], exp[8]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
